// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word geometry
// and the store-log format.
package dm_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Bytes per memory word (one enable bit per byte)
   localparam int WORD_BYTES = 4;

   // Store log line: issuing PC, byte address, merged word written
   localparam string LOG_FMT = "@%h: *%h <= %h";

endpackage

// File: rtl/dm_be_merge.sv
// Byte-enable merge: each byte of the result comes from the store data when
// its enable is set, otherwise from the word already in memory.
module dm_be_merge
   import dm_pkg::*;
(
   input  logic [31:0]           old_word,
   input  logic [31:0]           wdata,
   input  logic [WORD_BYTES-1:0] be,
   output logic [31:0]           merged
);

   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
      assign merged[8*gi +: 8] = be[gi] ? wdata[8*gi +: 8] : old_word[8*gi +: 8];
   end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// latency, performs the access on the edge that enters RESP and holds the
// response until the CPU takes it.
module dm_responder
   import dm_pkg::*;
#(
   parameter int DEPTH   = 3072,
   parameter int LATENCY = 2
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [WORD_BYTES-1:0] req_be,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [31:0]           req_pc,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err
);

   localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t                  state_reg, state_next;
   logic [3:0]              cnt_reg, cnt_next;

   logic                    we_reg;
   logic [WORD_BYTES-1:0]   be_reg;
   logic [31:0]             addr_reg;
   logic [31:0]             wdata_reg;
   logic [31:0]             pc_reg;

   logic [31:0]             rdata_reg;
   logic                    err_reg;

   logic [31:0]             mem [DEPTH];

   logic                    do_access;
   logic                    acc_we;
   logic [WORD_BYTES-1:0]   acc_be;
   logic [31:0]             acc_addr;
   logic [31:0]             acc_wdata;
   logic [31:0]             acc_pc;
   logic                    acc_err;
   logic [IDX_W-1:0]        acc_idx;
   logic [31:0]             old_word;
   logic [31:0]             merged;
   logic                    acc_write;

   assign req_ready  = (state_reg == IDLE);
   assign resp_valid = (state_reg == RESP);
   assign resp_rdata = rdata_reg;
   assign resp_err   = err_reg;

   // With LATENCY==1 the access happens on the accept edge itself, so the
   // live request inputs are used; otherwise the latched copy is used.
   always_comb begin
      acc_we    = we_reg;
      acc_be    = be_reg;
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
      acc_pc    = pc_reg;
      if (state_reg == IDLE) begin
         acc_we    = req_we;
         acc_be    = req_be;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_pc    = req_pc;
      end
   end

   assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
   assign acc_idx   = acc_addr[IDX_W+1:2];
   assign old_word  = mem[acc_idx];
   assign acc_write = do_access && !acc_err && acc_we && (acc_be != '0);

   dm_be_merge u_merge (
      .old_word (old_word),
      .wdata    (acc_wdata),
      .be       (acc_be),
      .merged   (merged)
   );

   // Next-state logic: IDLE -> WAIT (or RESP when LATENCY==1) -> RESP -> IDLE
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      do_access  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               cnt_next = LAT_M1;
               if (LATENCY == 1) begin
                  state_next = RESP;
                  do_access  = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) begin
               state_next = RESP;
               do_access  = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counter, request latch and response registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         we_reg    <= 1'b0;
         be_reg    <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         pc_reg    <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == IDLE && req_valid) begin
            we_reg    <= req_we;
            be_reg    <= req_be;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            pc_reg    <= req_pc;
         end
         if (do_access) begin
            err_reg   <= acc_err;
            rdata_reg <= (acc_err || acc_we) ? 32'd0 : old_word;
         end else if (state_reg == RESP && resp_ready) begin
            err_reg   <= 1'b0;
            rdata_reg <= '0;
         end
      end
   end

   // Storage: cleared on reset, byte-merged store committed on the access edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (acc_write) begin
         mem[acc_idx] <= merged;
      end
   end

`ifndef SYNTHESIS
   // Store log: one line per committed store with a non-zero byte enable
   always @(posedge clk) begin
      if (reset && acc_write) begin
         $display(LOG_FMT, acc_pc, acc_addr, merged);
      end
   end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a transaction-level memory model
// checked every cycle, plus directed transactions with literal expectations.
module tb_dm_responder;

   localparam int DEPTH   = 3072;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [3:0]  req_be = 4'h0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [31:0] req_pc = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dm_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_be     (req_be),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_pc     (req_pc),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // outstanding: a request has been accepted and not yet taken
   // age: cycles elapsed since the accept edge
   logic [31:0] mmem [DEPTH];
   bit          live = 1'b0;
   bit          outst = 1'b0;
   int          age = 0;
   logic [31:0] m_rdata = 32'h0;
   bit          m_err = 1'b0;
   bit          ev;
   int          midx;

   always @(negedge clk) begin
      if (live) begin
         ev = outst && (age >= LATENCY);
         check("m_req_ready",  32'(req_ready),  32'(!outst));
         check("m_resp_valid", 32'(resp_valid), 32'(ev));
         check("m_resp_rdata", resp_rdata,      ev ? m_rdata : 32'h0);
         check("m_resp_err",   32'(resp_err),   ev ? 32'(m_err) : 32'h0);
      end
      if (!reset) begin
         live  = 1'b1;
         outst = 1'b0;
         age   = 0;
         for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
      end else if (live) begin
         if (outst) begin
            if (age >= LATENCY && resp_ready) outst = 1'b0;
            else age++;
         end else if (req_valid) begin
            outst = 1'b1;
            age   = 1;
            midx  = int'(req_addr >> 2);
            m_err = (req_addr[1:0] != 2'b00) || (midx >= DEPTH) || (req_addr[31:30] != 2'b00);
            if (m_err) begin
               m_rdata = 32'h0;
            end else if (req_we) begin
               m_rdata = 32'h0;
               for (int b = 0; b < 4; b++)
                  if (req_be[b]) mmem[midx][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
               m_rdata = mmem[midx];
            end
         end
      end
   end

   // ---------------- directed transaction ----------------
   task automatic xact(input string tag, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input bit exp_err, input int hold);
      int n;
      req_we    = we;
      req_be    = be;
      req_addr  = addr;
      req_wdata = wdata;
      req_pc    = 32'h0040_0000 + addr;
      req_valid = 1'b1;
      resp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      check({tag, "_accept"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      // scramble request inputs after accept: the latched request must not change
      req_valid = 1'b0;
      req_we    = ~we;
      req_be    = ~be;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_pc    = $urandom;
      n = 1;
      while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
      check({tag, "_latency"}, 32'(n), 32'(LATENCY));
      check({tag, "_rdata"}, resp_rdata, exp_rd);
      check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         req_valid = ~req_valid;
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
         check({tag, "_hold_rdata"}, resp_rdata, exp_rd);
         check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, "_released"}, 32'(resp_valid), 32'd0);
      $display("xact %s we=%0d be=%b addr=%h wdata=%h -> rdata=%h err=%0d", tag, we, be, addr, wdata, exp_rd, exp_err);
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      check("rst_req_ready",  32'(req_ready),  32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata,      32'd0);
      check("rst_resp_err",   32'(resp_err),   32'd0);

      xact("ld0",       1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 0);
      xact("st10",      1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'h0,         1'b0, 0);
      xact("ld10",      1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 0);
      xact("st10_p",    1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD, 32'h0,      1'b0, 0);
      xact("ld10_p",    1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h12BB_56DD, 1'b0, 0);
      xact("ld3000",    1'b0, 4'hF, 32'h0000_3000, 32'h0,         32'h0,         1'b1, 0);
      xact("st6",       1'b1, 4'hF, 32'h0000_0006, 32'hFFFF_FFFF, 32'h0,         1'b1, 0);
      xact("ld10_keep", 1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h12BB_56DD, 1'b0, 0);
      xact("st10_be0",  1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0,         1'b0, 0);
      xact("ld10_be0",  1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h12BB_56DD, 1'b0, 0);
      xact("st_last",   1'b1, 4'hF, 32'h0000_2FFC, 32'hCAFE_F00D, 32'h0,         1'b0, 0);
      xact("ld_last",   1'b0, 4'hF, 32'h0000_2FFC, 32'h0,         32'hCAFE_F00D, 1'b0, 0);
      xact("ld_hold",   1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h12BB_56DD, 1'b0, 5);

      // reset during WAIT of a store to 0x20: the store must be dropped
      req_we    = 1'b1;
      req_be    = 4'hF;
      req_addr  = 32'h0000_0020;
      req_wdata = 32'h55AA_55AA;
      req_pc    = 32'h0040_0020;
      req_valid = 1'b1;
      check("abort_pre_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("abort_wait_ready", 32'(req_ready), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_req_ready",  32'(req_ready),  32'd1);
      xact("ld20_abort", 1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 0);
      xact("ld10_wiped", 1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 0);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
